// File: rtl/shift_rs.sv
// Reservation station feeding the shift FU: holds ops, wakes operands from the CDB, issues the oldest ready op.
// Optional macro RS_DISPATCH_BYPASS_EN: capture a matching CDB broadcast into a source in its dispatch cycle.
module shift_rs #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [7:0]          disp_operand,
    input  logic [1:0]          disp_dep_rdy,
    input  logic [2*TAG_W-1:0]  disp_dep_tag,
    input  logic [2*DATA_W-1:0] disp_dep_val,
    input  logic [7:0]          disp_wbs,
    input  logic [7:0]          disp_flags,
    input  logic [TAG_W-1:0]    disp_robid,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_id,
    input  logic [DATA_W-1:0]   cdb_val,
    input  logic                fu_busy,
    output logic                input_transmit,
    output logic [7:0]          operand,
    output logic [2*DATA_W-1:0] depvals,
    output logic [7:0]          wbs,
    output logic [7:0]          flags,
    output logic [TAG_W-1:0]    robid,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int AW = $clog2(DEPTH);

    logic                    e_valid [DEPTH];
    logic [1:0]              e_rdy   [DEPTH];
    logic [1:0][TAG_W-1:0]   e_tag   [DEPTH];
    logic [1:0][DATA_W-1:0]  e_val   [DEPTH];
    logic [7:0]              e_op    [DEPTH];
    logic [7:0]              e_wbs   [DEPTH];
    logic [7:0]              e_flags [DEPTH];
    logic [TAG_W-1:0]        e_robid [DEPTH];
    logic [AW-1:0]           e_age   [DEPTH];
    logic [AW:0]             occ_q;

    logic                    sel_found;
    logic [AW-1:0]           sel_idx;
    logic [AW-1:0]           sel_age;
    logic [AW-1:0]           free_idx;
    logic                    issue_fire;
    logic                    disp_fire;
    logic [1:0]              in_rdy;
    logic [1:0][TAG_W-1:0]   in_tag;
    logic [1:0][DATA_W-1:0]  in_val;
    logic [AW-1:0]           in_age;

    assign occupancy  = occ_q;
    assign disp_ready = (occ_q != (AW+1)'(DEPTH));
    assign disp_fire  = disp_valid && disp_ready;
    assign issue_fire = sel_found && !fu_busy;
    // Issued entry is always older than any new arrival, so the new rank shrinks by one on issue.
    assign in_age     = AW'(occ_q - (AW+1)'(issue_fire));

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && (e_rdy[i] == 2'b11) && (!sel_found || (e_age[i] < sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = AW'(i);
                sel_age   = e_age[i];
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!e_valid[i]) free_idx = AW'(i);
        end
    end

    always_comb begin
        in_rdy = disp_dep_rdy;
        in_tag = disp_dep_tag;
        in_val = disp_dep_val;
`ifdef RS_DISPATCH_BYPASS_EN
        for (int s = 0; s < 2; s++) begin
            if (!disp_dep_rdy[s] && cdb_valid && (in_tag[s] == cdb_id)) begin
                in_rdy[s] = 1'b1;
                in_val[s] = cdb_val;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                e_valid[i] <= 1'b0;
                e_rdy[i]   <= '0;
                e_tag[i]   <= '0;
                e_val[i]   <= '0;
                e_op[i]    <= '0;
                e_wbs[i]   <= '0;
                e_flags[i] <= '0;
                e_robid[i] <= '0;
                e_age[i]   <= '0;
            end
            occ_q          <= '0;
            input_transmit <= 1'b0;
            operand        <= '0;
            depvals        <= '0;
            wbs            <= '0;
            flags          <= '0;
            robid          <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) e_valid[i] <= 1'b0;
            occ_q          <= '0;
            input_transmit <= 1'b0;
        end else begin
            input_transmit <= issue_fire;
            if (issue_fire) begin
                operand          <= e_op[sel_idx];
                depvals          <= e_val[sel_idx];
                wbs              <= e_wbs[sel_idx];
                flags            <= e_flags[sel_idx];
                robid            <= e_robid[sel_idx];
                e_valid[sel_idx] <= 1'b0;
            end
            // Surviving entries: CDB wakeup and age compaction behind the issued op.
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && !(issue_fire && (AW'(i) == sel_idx))) begin
                    for (int s = 0; s < 2; s++) begin
                        if (cdb_valid && !e_rdy[i][s] && (e_tag[i][s] == cdb_id)) begin
                            e_rdy[i][s] <= 1'b1;
                            e_val[i][s] <= cdb_val;
                        end
                    end
                    if (issue_fire && (e_age[i] > sel_age)) e_age[i] <= e_age[i] - 1'b1;
                end
            end
            if (disp_fire) begin
                e_valid[free_idx] <= 1'b1;
                e_rdy[free_idx]   <= in_rdy;
                e_tag[free_idx]   <= in_tag;
                e_val[free_idx]   <= in_val;
                e_op[free_idx]    <= disp_operand;
                e_wbs[free_idx]   <= disp_wbs;
                e_flags[free_idx] <= disp_flags;
                e_robid[free_idx] <= disp_robid;
                e_age[free_idx]   <= in_age;
            end
            occ_q <= occ_q + (AW+1)'(disp_fire) - (AW+1)'(issue_fire);
        end
    end
endmodule

// File: tb/tb_shift_rs.sv
// Bench for shift_rs: age-ordered queue model checked every cycle, plus literal checks for the directed scenarios.
module tb_shift_rs;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic rst, flush, disp_valid, disp_ready;
    logic [7:0] disp_operand, disp_wbs, disp_flags;
    logic [1:0] disp_dep_rdy;
    logic [2*TAG_W-1:0] disp_dep_tag;
    logic [2*DATA_W-1:0] disp_dep_val;
    logic [TAG_W-1:0] disp_robid, cdb_id, robid;
    logic cdb_valid, fu_busy, input_transmit;
    logic [DATA_W-1:0] cdb_val;
    logic [7:0] operand, wbs, flags;
    logic [2*DATA_W-1:0] depvals;
    logic [$clog2(DEPTH):0] occupancy;

    shift_rs #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_operand(disp_operand), .disp_dep_rdy(disp_dep_rdy), .disp_dep_tag(disp_dep_tag),
        .disp_dep_val(disp_dep_val), .disp_wbs(disp_wbs), .disp_flags(disp_flags),
        .disp_robid(disp_robid), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val),
        .fu_busy(fu_busy), .input_transmit(input_transmit), .operand(operand), .depvals(depvals),
        .wbs(wbs), .flags(flags), .robid(robid), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue kept in dispatch order, so the oldest ready op is the first ready one.
    typedef struct packed {
        logic [1:0]             rdy;
        logic [1:0][TAG_W-1:0]  tag;
        logic [1:0][DATA_W-1:0] val;
        logic [7:0]             op;
        logic [7:0]             wbs;
        logic [7:0]             flags;
        logic [TAG_W-1:0]       robid;
    } op_t;

    op_t q[$];
    logic                m_it = 1'b0;
    logic [7:0]          m_op = '0, m_wbs = '0, m_flags = '0;
    logic [2*DATA_W-1:0] m_dv = '0;
    logic [TAG_W-1:0]    m_robid = '0;

    always @(posedge clk) begin : model
        int found;
        bit acc;
        op_t e;
        if (!rst) begin
            q.delete();
            m_it = 0; m_op = '0; m_wbs = '0; m_flags = '0; m_dv = '0; m_robid = '0;
        end else if (flush) begin
            q.delete();
            m_it = 0;
        end else begin
            acc = disp_valid && (q.size() < DEPTH);
            found = -1;
            for (int k = 0; k < q.size(); k++)
                if (found < 0 && q[k].rdy == 2'b11) found = k;
            m_it = (found >= 0) && !fu_busy;
            if (m_it) begin
                e = q[found];
                m_op = e.op; m_wbs = e.wbs; m_flags = e.flags; m_dv = e.val; m_robid = e.robid;
                q.delete(found);
            end
            if (cdb_valid) begin
                for (int k = 0; k < q.size(); k++) begin
                    e = q[k];
                    for (int s = 0; s < 2; s++)
                        if (!e.rdy[s] && e.tag[s] == cdb_id) begin
                            e.rdy[s] = 1'b1;
                            e.val[s] = cdb_val;
                        end
                    q[k] = e;
                end
            end
            if (acc) begin
                e.rdy = disp_dep_rdy; e.tag = disp_dep_tag; e.val = disp_dep_val;
                e.op = disp_operand; e.wbs = disp_wbs; e.flags = disp_flags; e.robid = disp_robid;
`ifdef RS_DISPATCH_BYPASS_EN
                for (int s = 0; s < 2; s++)
                    if (!e.rdy[s] && cdb_valid && e.tag[s] == cdb_id) begin
                        e.rdy[s] = 1'b1;
                        e.val[s] = cdb_val;
                    end
`endif
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("input_transmit", 32'(input_transmit), 32'(m_it));
        chk("occupancy", 32'(occupancy), 32'(q.size()));
        chk("disp_ready", 32'(disp_ready), 32'(q.size() < DEPTH));
        chk("operand", 32'(operand), 32'(m_op));
        chk("depvals", 32'(depvals), 32'(m_dv));
        chk("wbs", 32'(wbs), 32'(m_wbs));
        chk("flags", 32'(flags), 32'(m_flags));
        chk("robid", 32'(robid), 32'(m_robid));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        disp_valid = 0; cdb_valid = 0; flush = 0;
    endtask

    task automatic set_disp(input logic [7:0] op, input logic [1:0] rdy, input logic [3:0] ta,
                            input logic [3:0] tb, input logic [7:0] va, input logic [7:0] vb,
                            input logic [3:0] rid);
        disp_valid = 1; disp_operand = op; disp_dep_rdy = rdy;
        disp_dep_tag = {ta, tb}; disp_dep_val = {va, vb};
        disp_wbs = op ^ 8'hA5; disp_flags = {1'b1, op[6:0]}; disp_robid = rid;
    endtask

    task automatic set_cdb(input logic [3:0] id, input logic [7:0] val);
        cdb_valid = 1; cdb_id = id; cdb_val = val;
    endtask

    initial begin
        rst = 0; fu_busy = 0; idle_in();
        set_disp(8'h00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 4'h0);
        disp_valid = 0;
        set_cdb(4'h0, 8'h00);
        cdb_valid = 0;
        cyc(); cyc();
        chk("rst_it", 32'(input_transmit), 32'h0);
        chk("rst_occ", 32'(occupancy), 32'h0);
        chk("rst_ready", 32'(disp_ready), 32'h1);
        rst = 1;
        cyc();

        // Both sources ready: strobe one cycle after the entry lands.
        set_disp(8'h02, 2'b11, 4'h0, 4'h0, 8'h81, 8'h03, 4'h1);
        cyc(); idle_in(); cyc();
        chk("t1_it", 32'(input_transmit), 32'h1);
        chk("t1_dv", 32'(depvals), 32'h8103);
        chk("t1_op", 32'(operand), 32'h02);
        cyc();
        chk("t1_it_drop", 32'(input_transmit), 32'h0);

        // Source b waits on tag 5.
        set_disp(8'h12, 2'b10, 4'h0, 4'h5, 8'h40, 8'h00, 4'h2);
        cyc(); idle_in(); cyc();
        set_cdb(4'h5, 8'h02);
        cyc(); idle_in();
        chk("t2_no_bypass_issue", 32'(input_transmit), 32'h0);
        cyc();
        chk("t2_it", 32'(input_transmit), 32'h1);
        chk("t2_b", 32'(depvals[7:0]), 32'h02);
        cyc();

        // Fill while FU stalled, then drain in order while a dispatch meets a full RS.
        fu_busy = 1;
        for (int k = 0; k < 4; k++) begin
            set_disp(8'h20 + 8'(k), 2'b11, 4'h0, 4'h0, 8'(k), 8'h01, 4'(k + 4));
            cyc();
        end
        idle_in();
        chk("t3_ready", 32'(disp_ready), 32'h0);
        chk("t3_occ", 32'(occupancy), 32'h4);
        fu_busy = 0;
        set_disp(8'h30, 2'b11, 4'h0, 4'h0, 8'hF0, 8'h02, 4'hC);
        cyc();
        chk("t4_op0", 32'(operand), 32'h20);
        chk("t4_occ", 32'(occupancy), 32'h3);
        chk("t4_ready", 32'(disp_ready), 32'h1);
        cyc(); idle_in();
        chk("t4_op1", 32'(operand), 32'h21);
        chk("t4_occ_same", 32'(occupancy), 32'h3);
        cyc(); chk("t4_op2", 32'(operand), 32'h22);
        cyc(); chk("t4_op3", 32'(operand), 32'h23);
        cyc(); chk("t4_op4", 32'(operand), 32'h30);
        cyc(); chk("t4_empty", 32'(occupancy), 32'h0);

        // Flush with a concurrent dispatch.
        fu_busy = 1;
        for (int k = 0; k < 3; k++) begin
            set_disp(8'h60 + 8'(k), 2'b11, 4'h0, 4'h0, 8'h11, 8'h22, 4'(k));
            cyc();
        end
        set_disp(8'h6F, 2'b11, 4'h0, 4'h0, 8'h33, 8'h44, 4'h9);
        flush = 1;
        cyc(); idle_in(); fu_busy = 0;
        chk("t5_occ", 32'(occupancy), 32'h0);
        chk("t5_it", 32'(input_transmit), 32'h0);
        cyc();
        chk("t5_lost", 32'(input_transmit), 32'h0);

        // Younger ready op overtakes an older waiting one.
        set_disp(8'h40, 2'b10, 4'h0, 4'h3, 8'h77, 8'h00, 4'h1);
        cyc();
        set_disp(8'h41, 2'b11, 4'h0, 4'h0, 8'h66, 8'h05, 4'h2);
        cyc(); idle_in(); cyc();
        chk("t7_young", 32'(operand), 32'h41);
        set_cdb(4'h3, 8'h09);
        cyc(); idle_in(); cyc();
        chk("t7_old", 32'(operand), 32'h40);
        chk("t7_dv", 32'(depvals), 32'h7709);

        // Both sources on one tag.
        set_disp(8'h50, 2'b00, 4'h9, 4'h9, 8'h00, 8'h00, 4'h3);
        cyc(); idle_in();
        set_cdb(4'h9, 8'h55);
        cyc(); idle_in(); cyc();
        chk("t8_dv", 32'(depvals), 32'h5555);
        cyc();

        // CDB broadcast in the dispatch cycle.
        set_disp(8'h70, 2'b01, 4'h7, 4'h0, 8'h00, 8'h01, 4'h5);
        set_cdb(4'h7, 8'h44);
        cyc(); idle_in(); cyc();
`ifdef RS_DISPATCH_BYPASS_EN
        chk("t6_bypass_it", 32'(input_transmit), 32'h1);
        chk("t6_bypass_dv", 32'(depvals), 32'h4401);
`else
        chk("t6_nobypass_it", 32'(input_transmit), 32'h0);
        chk("t6_nobypass_occ", 32'(occupancy), 32'h1);
`endif
        flush = 1; cyc(); idle_in(); cyc();

        // Reset mid-operation zeroes everything.
        fu_busy = 1;
        set_disp(8'h7E, 2'b11, 4'h0, 4'h0, 8'h12, 8'h34, 4'h6);
        cyc(); idle_in();
        rst = 0;
        cyc();
        chk("rst2_op", 32'(operand), 32'h0);
        chk("rst2_dv", 32'(depvals), 32'h0);
        chk("rst2_occ", 32'(occupancy), 32'h0);
        rst = 1; fu_busy = 0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
